// File: rtl/spram_rr_arbiter_pkg.sv
// Shared types for the two-port round-robin front end of the single-port sine-table RAM.
package spram_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef logic port_id_t;

  // One RAM command as presented by a requester; the mux selects a whole command.
  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/spram_rr_arbiter_rr_arb2.sv
// Two-way round-robin grant with the last_grant register; the loser of a conflict wins the next one.
module rr_arb2
  import spram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  port_id_t last_q;
  port_id_t last_d;

  always_comb begin
    grant  = 2'b00;
    last_d = last_q;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_q == 1'b1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (grant[0]) begin
      last_d = 1'b0;
    end else if (grant[1]) begin
      last_d = 1'b1;
    end
  end

  // Reset to port 1 so that port 0 takes the first contested cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/spram_rr_arbiter.sv
// Shares one read-first, synchronous-read RAM between two valid/ready requesters;
// read data returns to the granted port one cycle later, tagged by rvalid.
module spram_rr_arbiter
  import spram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_rvalid,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_rvalid,
  output logic [DW-1:0] req1_rdata,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q,
  output logic [CW-1:0] conflicts
);

  logic [1:0]    valid;
  logic [1:0]    grant;
  mem_cmd_t      cmd [2];
  mem_cmd_t      sel_cmd;
  logic [1:0]    rvalid_q;
  logic [1:0]    rvalid_d;
  logic [DW-1:0] rdata [2];
  logic [CW-1:0] conflicts_q;
  logic [CW-1:0] conflicts_d;

  assign valid = {req1_valid, req0_valid};

  // The command struct is sized to the package defaults; non-default AW/DW need the package widened.
  assign cmd[0] = '{we: req0_we, addr: AW_DEF'(req0_addr), wdata: DW_DEF'(req0_wdata)};
  assign cmd[1] = '{we: req1_we, addr: AW_DEF'(req1_addr), wdata: DW_DEF'(req1_wdata)};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .grant (grant)
  );

  always_comb begin
    sel_cmd = '0;
    if (grant[0]) begin
      sel_cmd = cmd[0];
    end else if (grant[1]) begin
      sel_cmd = cmd[1];
    end
  end

  assign mem_a  = AW'(sel_cmd.addr);
  assign mem_d  = DW'(sel_cmd.wdata);
  // Gate with rst so no write can reach the RAM while reset is held.
  assign mem_we = sel_cmd.we & ~rst;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign rvalid_d[gi] = grant[gi] & ~cmd[gi].we;
    assign rdata[gi]    = rvalid_q[gi] ? mem_q : '0;
  end

  always_comb begin
    conflicts_d = conflicts_q;
    if ((&valid) && !(&conflicts_q)) begin
      conflicts_d = conflicts_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q    <= 2'b00;
      conflicts_q <= '0;
    end else begin
      rvalid_q    <= rvalid_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign req0_rvalid = rvalid_q[0];
  assign req1_rvalid = rvalid_q[1];
  assign req0_rdata  = rdata[0];
  assign req1_rdata  = rdata[1];
  assign conflicts   = conflicts_q;

endmodule
